// File: rtl/fp29i_fp16_pack.sv
// Packs one FP29i word (sign, 6b exp bias 31, 22b unnormalised mantissa) into IEEE binary16 with RNE rounding and flags.
// Latency: 3 cycles from accept edge to dout (input reg -> LZD -> align -> round/pack), 1 word/cycle.
// Backpressure: single global advance (~out_valid | out_ready) stalls every stage; in_ready mirrors it, bubbles are kept.
module fp29i_fp16_pack #(
    parameter bit SAT_OVF = 1'b0,
    parameter bit FTZ     = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        din_uni_y_sgn,
    input  logic [5:0]  din_uni_y_exp,
    input  logic [21:0] din_uni_y_man_dn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] dout_fp16,
    output logic [2:0]  dout_flags,
    output logic [2:0]  sticky_flags,
    input  logic        flag_clr
);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------- S1: input register + leading-zero detect ----------------
    logic        s1_vld;
    logic        s1_sgn;
    logic [5:0]  s1_exp;
    logic [21:0] s1_man;
    logic [4:0]  s1_lz;
    logic        s1_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_sgn <= 1'b0;
            s1_exp <= '0;
            s1_man <= '0;
        end else if (adv) begin
            s1_vld <= in_valid;
            s1_sgn <= din_uni_y_sgn;
            s1_exp <= din_uni_y_exp;
            s1_man <= din_uni_y_man_dn;
        end
    end

    // Ascending scan: the highest set bit is the last one to write s1_lz.
    always_comb begin
        s1_lz = 5'd21;
        for (int i = 0; i <= 21; i++) begin
            if (s1_man[i]) s1_lz = 5'(21 - i);
        end
    end

    assign s1_zero = (s1_man == '0);

    // ---------------- S2: normalise and align to the fp16 grid ----------------
    logic        s2_vld;
    logic        s2_sgn;
    logic [5:0]  s2_exp;
    logic [21:0] s2_man;
    logic [4:0]  s2_lz;
    logic        s2_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sgn  <= 1'b0;
            s2_exp  <= '0;
            s2_man  <= '0;
            s2_lz   <= '0;
            s2_zero <= 1'b0;
        end else if (adv) begin
            s2_vld  <= s1_vld;
            s2_sgn  <= s1_sgn;
            s2_exp  <= s1_exp;
            s2_man  <= s1_man;
            s2_lz   <= s1_lz;
            s2_zero <= s1_zero;
        end
    end

    logic [21:0]       s2_nsig;
    logic signed [6:0] s2_e;
    logic [6:0]        s2_sh;
    logic [43:0]       s2_wide;
    logic [21:0]       s2_sig;
    logic              s2_stk;
    logic [4:0]        s2_ef;
    logic              s2_tiny;
    logic              s2_ovf;

    always_comb begin
        s2_nsig = s2_man << s2_lz;
        s2_e    = $signed({1'b0, s2_exp}) - 7'sd16 - $signed({2'b00, s2_lz});
        s2_sh   = 7'd1 - $unsigned(s2_e);
        s2_wide = {s2_nsig, 22'd0} >> s2_sh;
        s2_tiny = (s2_e < 7'sd1);
        s2_ovf  = (s2_e >= 7'sd31);
        s2_sig  = s2_nsig;
        s2_stk  = 1'b0;
        s2_ef   = s2_e[4:0];
        if (s2_tiny) begin
            s2_ef = 5'd0;
            // Beyond 22 places nothing reaches the guard bit; only sticky survives.
            if (s2_sh >= 7'd23) begin
                s2_sig = '0;
                s2_stk = ~s2_zero;
            end else begin
                s2_sig = s2_wide[43:22];
                s2_stk = |s2_wide[21:0];
            end
        end
    end

    // ---------------- S3: round to nearest even and pack ----------------
    logic        s3_vld;
    logic        s3_sgn;
    logic [21:0] s3_sig;
    logic        s3_stk;
    logic [4:0]  s3_ef;
    logic        s3_tiny;
    logic        s3_ovf;
    logic        s3_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld  <= 1'b0;
            s3_sgn  <= 1'b0;
            s3_sig  <= '0;
            s3_stk  <= 1'b0;
            s3_ef   <= '0;
            s3_tiny <= 1'b0;
            s3_ovf  <= 1'b0;
            s3_zero <= 1'b0;
        end else if (adv) begin
            s3_vld  <= s2_vld;
            s3_sgn  <= s2_sgn;
            s3_sig  <= s2_sig;
            s3_stk  <= s2_stk;
            s3_ef   <= s2_ef;
            s3_tiny <= s2_tiny;
            s3_ovf  <= s2_ovf;
            s3_zero <= s2_zero;
        end
    end

    logic [9:0]  s3_frac;
    logic        s3_guard;
    logic        s3_stk_all;
    logic        s3_rup;
    logic [14:0] s3_sum;
    logic        s3_ovf_all;
    logic        s3_inexact;
    logic [15:0] s3_res;
    logic [2:0]  s3_flags;

    always_comb begin
        s3_frac    = s3_sig[20:11];
        s3_guard   = s3_sig[10];
        s3_stk_all = s3_stk | (|s3_sig[9:0]);
        s3_rup     = s3_guard & (s3_stk_all | s3_frac[0]);
        // Mantissa carry ripples into the exponent: subnormal->normal and binade steps come for free.
        s3_sum     = {s3_ef, s3_frac} + {14'd0, s3_rup};
        s3_ovf_all = s3_ovf | (s3_sum[14:10] == 5'd31);
        s3_inexact = s3_guard | s3_stk_all;
        s3_res     = {s3_sgn, s3_sum};
        s3_flags   = {1'b0, s3_tiny & s3_inexact, s3_inexact};
        if (s3_zero) begin
            s3_res   = {s3_sgn, 15'd0};
            s3_flags = 3'b000;
        end else if (s3_ovf_all) begin
            s3_res   = {s3_sgn, (SAT_OVF ? 15'h7BFF : 15'h7C00)};
            s3_flags = 3'b101;
        end else if (FTZ && s3_tiny) begin
            s3_res   = {s3_sgn, 15'd0};
            s3_flags = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            dout_fp16  <= '0;
            dout_flags <= '0;
        end else if (adv) begin
            out_valid  <= s3_vld;
            dout_fp16  <= s3_res;
            dout_flags <= s3_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else if (flag_clr) begin
            sticky_flags <= '0;
        end else if (out_valid && out_ready) begin
            sticky_flags <= sticky_flags | dout_flags;
        end
    end

endmodule
